// File: rtl/out_reg_sched.sv
// out_reg_sched: round-robin owner of one shared OUT_REG pad; streams a granted requester's bits,
// then runs a gap phase that resets the pad. Define OUT_REG_SCHED_BYPASS_EN to add cfg_bypass.
module out_reg_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned STALL_MAX  = 15
) (
    input  logic               clk,
    input  logic               rst,
`ifdef OUT_REG_SCHED_BYPASS_EN
    input  logic               cfg_bypass,
`endif
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_bit,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic               pad_data,
    output logic               pad_sel,
    output logic               pad_rst,
    output logic               abort,
    output logic [15:0]        bits_sent
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [7:0]    stall_cnt;
    logic [GW-1:0] gap_cnt;
    logic          byp_q;

    logic          arb_found;
    logic [PW-1:0] arb_winner;
    logic [PW-1:0] ptr_next;
    int unsigned   idx;
    logic          accept;
    logic          stall_hit;

    // First valid requester at or after the pointer, wrapping at NUM_REQ.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!arb_found && req_valid[PW'(idx)]) begin
                arb_found  = 1'b1;
                arb_winner = PW'(idx);
            end
        end
    end

    assign ptr_next  = (arb_winner == PW'(NUM_REQ - 1)) ? '0 : arb_winner + PW'(1);
    assign accept    = |(req_valid & grant);
    assign stall_hit = (stall_cnt == 8'(STALL_MAX - 1));
    assign req_ready = grant;

`ifdef OUT_REG_SCHED_BYPASS_EN
    assign pad_sel = byp_q & (state == S_BUSY);
`else
    assign pad_sel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            byp_q     <= 1'b0;
            grant     <= '0;
            pad_data  <= 1'b0;
            pad_rst   <= 1'b1;
            abort     <= 1'b0;
            bits_sent <= '0;
        end else begin
            abort   <= 1'b0;
            pad_rst <= 1'b0;
            case (state)
                S_IDLE: begin
                    pad_data <= 1'b0;
                    if (arb_found) begin
                        state     <= S_BUSY;
                        owner     <= arb_winner;
                        grant     <= NUM_REQ'(1) << arb_winner;
                        ptr       <= ptr_next;
                        bits_sent <= '0;
                        stall_cnt <= '0;
`ifdef OUT_REG_SCHED_BYPASS_EN
                        byp_q     <= cfg_bypass;
`else
                        byp_q     <= 1'b0;
`endif
                    end
                end
                S_BUSY: begin
                    if (accept) begin
                        // The final bit still lands on pad_data in the first gap cycle.
                        pad_data  <= req_bit[owner];
                        stall_cnt <= '0;
                        if (bits_sent != '1) begin
                            bits_sent <= bits_sent + 16'd1;
                        end
                        if (req_last[owner]) begin
                            state   <= S_GAP;
                            grant   <= '0;
                            gap_cnt <= '0;
                            pad_rst <= 1'b1;
                        end
                    end else if (stall_hit) begin
                        abort    <= 1'b1;
                        state    <= S_GAP;
                        grant    <= '0;
                        gap_cnt  <= '0;
                        pad_rst  <= 1'b1;
                        pad_data <= 1'b0;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    pad_data <= 1'b0;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
